// File: rtl/draw_nxt_queue.sv
// Overlays a queue of upcoming tetrominoes as bevelled squares on the VGA stream, 2-cycle latency.
// Optional NXT_DIM_EN: slots 1..SLOTS-1 drawn at half brightness, slot 0 stays full.
module draw_nxt_queue #(
  parameter int X_ORIGIN   = 26,
  parameter int Y_ORIGIN   = 25,
  parameter int SIZE       = 35,
  parameter int BEVEL      = 3,
  parameter int SLOTS      = 3,
  parameter int SLOT_PITCH = 80
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic        push,
  input  logic [4:0]  push_block,
  input  logic        clr,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic [4:0]  next_block
);

  typedef enum logic [1:0] {SH_NORMAL = 2'd0, SH_LIGHT = 2'd1, SH_DARK = 2'd2} shade_t;

  typedef struct packed {
    logic       hit;
    shade_t     shade;
    logic [4:0] code;
  } probe_t;

  // Occupied cells of the 4x2 bounding box, bit index = row*4 + col.
  function automatic logic [7:0] shape_mask(input logic [4:0] code);
    case (code)
      5'h10:   return 8'h0F;
      5'h11:   return 8'h66;
      5'h12:   return 8'h27;
      5'h13:   return 8'h36;
      5'h14:   return 8'h63;
      5'h15:   return 8'h47;
      5'h16:   return 8'h17;
      default: return 8'h00;
    endcase
  endfunction

  function automatic shade_t shade_of(input int lx, input int ly);
    if ((lx < BEVEL || ly < BEVEL) && (lx + ly < SIZE - 1)) return SH_LIGHT;
    if (lx >= SIZE - BEVEL || ly >= SIZE - BEVEL)           return SH_DARK;
    return SH_NORMAL;
  endfunction

  function automatic logic [11:0] piece_rgb(input logic [4:0] code, input shade_t shade);
    logic [35:0] pal;
    case (code)
      5'h10:   pal = {12'hfab, 12'h800, 12'hf00};
      5'h11:   pal = {12'hff8, 12'hbb6, 12'hff0};
      5'h12:   pal = {12'he8e, 12'h808, 12'hf0f};
      5'h13:   pal = {12'h9f9, 12'h080, 12'h0f0};
      5'h14:   pal = {12'h0bf, 12'h008, 12'h00f};
      5'h15:   pal = {12'hcff, 12'h0cf, 12'h0ff};
      5'h16:   pal = {12'hfc8, 12'h840, 12'hf80};
      default: pal = '0;
    endcase
    case (shade)
      SH_LIGHT: return pal[35:24];
      SH_DARK:  return pal[23:12];
      default:  return pal[11:0];
    endcase
  endfunction

  // Signed int arithmetic keeps off-screen cell origins from wrapping onto visible pixels.
  function automatic probe_t probe(input logic [10:0] hc, input logic [10:0] vc,
                                   input int oy, input logic [4:0] code);
    probe_t     res;
    logic [7:0] mask;
    int         lx;
    int         ly;
    res       = '0;
    res.shade = SH_NORMAL;
    res.code  = code;
    mask      = shape_mask(code);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) begin
        lx = int'(hc) - (X_ORIGIN + c * SIZE);
        ly = int'(vc) - (oy + r * SIZE);
        if (mask[r*4+c] && lx >= 0 && lx < SIZE && ly >= 0 && ly < SIZE) begin
          res.hit   = 1'b1;
          res.shade = shade_of(lx, ly);
        end
      end
    end
    return res;
  endfunction

  logic [4:0] live_q   [SLOTS];
  logic [4:0] shadow_q [SLOTS];
  logic       vblnk_prev;

  // NOTE: the queue is a handful of flops, not a RAM, so it is reset like any other state.
  always_ff @(posedge pclk) begin
    if (rst) begin
      for (int k = 0; k < SLOTS; k++) begin
        live_q[k]   <= '0;
        shadow_q[k] <= '0;
      end
      vblnk_prev <= 1'b0;
    end else begin
      vblnk_prev <= vblnk_in;
      if (vblnk_in && !vblnk_prev) begin
        for (int k = 0; k < SLOTS; k++) shadow_q[k] <= live_q[k];
      end
      if (clr) begin
        for (int k = 0; k < SLOTS; k++) live_q[k] <= '0;
      end else if (push) begin
        for (int k = 0; k < SLOTS - 1; k++) live_q[k] <= live_q[k+1];
        live_q[SLOTS-1] <= push_block;
      end
    end
  end

  assign next_block = live_q[0];

  probe_t probe_c [SLOTS];

  // NOTE: every always_comb output is assigned on all paths, so no latch can be inferred.
  always_comb begin
    for (int s = 0; s < SLOTS; s++) begin
      probe_c[s] = probe(hcount_in, vcount_in, Y_ORIGIN + s * SLOT_PITCH, shadow_q[s]);
    end
  end

  probe_t      probe_d1 [SLOTS];
  logic [10:0] hcount_d1;
  logic [10:0] vcount_d1;
  logic        hsync_d1;
  logic        vsync_d1;
  logic        hblnk_d1;
  logic        vblnk_d1;
  logic [11:0] rgb_d1;

  // NOTE: state is updated with <= only, so every stage samples its predecessor's old value.
  always_ff @(posedge pclk) begin
    if (rst) begin
      for (int s = 0; s < SLOTS; s++) probe_d1[s] <= '0;
      hcount_d1 <= '0;
      vcount_d1 <= '0;
      hsync_d1  <= 1'b0;
      vsync_d1  <= 1'b0;
      hblnk_d1  <= 1'b0;
      vblnk_d1  <= 1'b0;
      rgb_d1    <= '0;
    end else begin
      for (int s = 0; s < SLOTS; s++) probe_d1[s] <= probe_c[s];
      hcount_d1 <= hcount_in;
      vcount_d1 <= vcount_in;
      hsync_d1  <= hsync_in;
      vsync_d1  <= vsync_in;
      hblnk_d1  <= hblnk_in;
      vblnk_d1  <= vblnk_in;
      rgb_d1    <= rgb_in;
    end
  end

  logic [11:0] pix_c;

  // Scanning from the highest slot down lets the lowest hit index overwrite the rest.
  always_comb begin
    pix_c = rgb_d1;
    for (int s = SLOTS - 1; s >= 0; s--) begin
      if (probe_d1[s].hit) begin
        pix_c = piece_rgb(probe_d1[s].code, probe_d1[s].shade);
`ifdef NXT_DIM_EN
        if (s != 0) pix_c = (pix_c >> 1) & 12'h777;
`endif
      end
    end
    if (hblnk_d1 || vblnk_d1) pix_c = '0;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= hcount_d1;
      vcount_out <= vcount_d1;
      hsync_out  <= hsync_d1;
      vsync_out  <= vsync_d1;
      hblnk_out  <= hblnk_d1;
      vblnk_out  <= vblnk_d1;
      rgb_out    <= pix_c;
    end
  end

endmodule

// File: tb/tb_draw_nxt_queue.sv
// Directed bench for draw_nxt_queue: queue order, frame shadowing, geometry, shading and reset.
module tb_draw_nxt_queue;

  logic        pclk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in;
  logic        push, clr;
  logic [4:0]  push_block;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;
  logic [4:0]  next_block;

  draw_nxt_queue dut (
    .pclk(pclk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .push(push), .push_block(push_block), .clr(clr),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .next_block(next_block)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [10:0] hc;
    logic [10:0] vc;
    logic        hs;
    logic        vs;
    logic        hb;
    logic [11:0] rgb;
    logic [11:0] exp;
  } px_t;

  px_t vq[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic px_t px(input int hc, input int vc, input int hs, input int vs,
                             input int hb, input int rgb, input int exp);
    px_t p;
    p.hc = 11'(hc); p.vc = 11'(vc); p.hs = hs[0]; p.vs = vs[0]; p.hb = hb[0];
    p.rgb = 12'(rgb); p.exp = 12'(exp);
    return p;
  endfunction

  // Expected colour of a slot 1..SLOTS-1 pixel.
  function automatic int dm(input int c);
`ifdef NXT_DIM_EN
    return (c >> 1) & 'h777;
`else
    return c;
`endif
  endfunction

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic drive_px(input px_t p);
    hcount_in = p.hc; vcount_in = p.vc; hsync_in = p.hs; vsync_in = p.vs;
    hblnk_in = p.hb; rgb_in = p.rgb;
  endtask

  // Streams queued pixels back to back; each is expected exactly two edges after it is driven.
  task automatic stream(input string tag);
    px_t idle;
    idle = px(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i <= vq.size(); i++) begin
      if (i < vq.size()) drive_px(vq[i]);
      else drive_px(idle);
      tick();
      if (i > 0) begin
        check($sformatf("%s[%0d] rgb", tag, i-1), 32'(rgb_out), 32'(vq[i-1].exp));
        check($sformatf("%s[%0d] hcount", tag, i-1), 32'(hcount_out), 32'(vq[i-1].hc));
        check($sformatf("%s[%0d] vcount", tag, i-1), 32'(vcount_out), 32'(vq[i-1].vc));
        check($sformatf("%s[%0d] hsync", tag, i-1), 32'(hsync_out), 32'(vq[i-1].hs));
        check($sformatf("%s[%0d] vsync", tag, i-1), 32'(vsync_out), 32'(vq[i-1].vs));
        check($sformatf("%s[%0d] hblnk", tag, i-1), 32'(hblnk_out), 32'(vq[i-1].hb));
        check($sformatf("%s[%0d] vblnk", tag, i-1), 32'(vblnk_out), 32'(0));
      end
    end
    vq.delete();
  endtask

  task automatic push_one(input logic [4:0] code);
    push = 1'b1; push_block = code;
    tick();
    push = 1'b0;
  endtask

  task automatic vblank_rise(input logic with_push, input logic [4:0] code);
    vblnk_in = 1'b1; push = with_push; push_block = code;
    tick();
    vblnk_in = 1'b0; push = 1'b0;
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " hcount_out"}, 32'(hcount_out), 32'(0));
    check({tag, " vcount_out"}, 32'(vcount_out), 32'(0));
    check({tag, " hsync_out"},  32'(hsync_out),  32'(0));
    check({tag, " vsync_out"},  32'(vsync_out),  32'(0));
    check({tag, " hblnk_out"},  32'(hblnk_out),  32'(0));
    check({tag, " vblnk_out"},  32'(vblnk_out),  32'(0));
    check({tag, " rgb_out"},    32'(rgb_out),    32'(0));
    check({tag, " next_block"}, 32'(next_block), 32'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with busy inputs: everything must read 0.
    rst = 1'b1; clr = 1'b0; push = 1'b1; push_block = 5'h10;
    hcount_in = 11'd26; vcount_in = 11'd25; hsync_in = 1'b1; vsync_in = 1'b1;
    hblnk_in = 1'b0; vblnk_in = 1'b0; rgb_in = 12'hfff;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0; push = 1'b0;
    drive_px(px(0, 0, 0, 0, 0, 0, 0));
    tick();

    push_one(5'h10); check("push1 next_block", 32'(next_block), 32'(0));
    push_one(5'h11); check("push2 next_block", 32'(next_block), 32'(0));
    push_one(5'h12); check("push3 next_block", 32'(next_block), 32'h10);

    // Frame 1: slots I, O, T.
    vblank_rise(1'b0, 5'h0);
    vq.push_back(px( 26,  25, 1, 0, 0, 'h123, 'hfab));
    vq.push_back(px( 43,  42, 0, 1, 0, 'h456, 'hf00));
    vq.push_back(px( 60,  45, 1, 1, 0, 'h789, 'h800));
    vq.push_back(px(166,  25, 0, 0, 0, 'habc, 'habc));
    vq.push_back(px(165,  25, 1, 0, 0, 'h111, 'h800));
    vq.push_back(px( 25,  25, 0, 0, 0, 'h321, 'h321));
    vq.push_back(px( 59,  25, 0, 1, 0, 'h010, 'hfab));
    vq.push_back(px( 60,  25, 0, 0, 0, 'h020, 'h800));
    vq.push_back(px( 28,  56, 1, 0, 0, 'h030, 'hfab));
    vq.push_back(px( 28,  57, 0, 0, 0, 'h040, 'h800));
    vq.push_back(px( 29,  28, 0, 0, 0, 'h050, 'hf00));
    vq.push_back(px( 26,  60, 1, 1, 0, 'h222, 'h222));
    vq.push_back(px( 26, 100, 0, 0, 0, 'haaa, 'haaa));
    vq.push_back(px( 78, 130, 0, 0, 0, 'h333, dm('hff0)));
    vq.push_back(px( 61, 105, 1, 0, 0, 'h444, dm('hff8)));
    vq.push_back(px( 26, 105, 0, 0, 0, 'h555, 'h555));
    vq.push_back(px( 78, 237, 0, 1, 0, 'h666, dm('hf0f)));
    vq.push_back(px(130, 219, 0, 0, 0, 'h777, dm('h808)));
    vq.push_back(px( 26,  25, 1, 0, 1, 'h999, 'h000));
    stream("frame1");

    // Mid-frame push must not change the current picture.
    push_one(5'h14);
    check("midframe next_block", 32'(next_block), 32'h11);
    vq.push_back(px( 26,  25, 0, 0, 0, 'h123, 'hfab));
    vq.push_back(px( 61,  25, 0, 0, 0, 'h124, 'hfab));
    stream("midframe");

    // Push on the vblank-rise cycle lands in live queue only.
    vblank_rise(1'b1, 5'h13);
    check("rise+push next_block", 32'(next_block), 32'h12);
    vq.push_back(px( 26,  25, 0, 0, 0, 'h125, 'h125));
    vq.push_back(px( 61,  25, 0, 0, 0, 'h126, 'hff8));
    vq.push_back(px( 61, 105, 0, 0, 0, 'h127, dm('he8e)));
    vq.push_back(px( 26, 185, 0, 0, 0, 'h128, dm('h0bf)));
    stream("frame2");

    vblank_rise(1'b0, 5'h0);
    vq.push_back(px( 61,  25, 0, 0, 0, 'h129, 'he8e));
    vq.push_back(px( 26,  60, 0, 0, 0, 'h12a, 'h12a));
    vq.push_back(px( 26, 105, 0, 0, 0, 'h12b, dm('h0bf)));
    vq.push_back(px( 26, 185, 0, 0, 0, 'h12c, 'h12c));
    vq.push_back(px( 26, 220, 0, 0, 0, 'h12d, dm('h9f9)));
    stream("frame3");

    // clr beats push; shadow keeps drawing until the next vblank.
    clr = 1'b1; push = 1'b1; push_block = 5'h15;
    tick();
    clr = 1'b0; push = 1'b0;
    check("clr+push next_block", 32'(next_block), 32'(0));
    vq.push_back(px( 61,  25, 0, 0, 0, 'h200, 'he8e));
    stream("afterclr");
    vblank_rise(1'b0, 5'h0);
    vq.push_back(px( 61,  25, 0, 0, 0, 'h321, 'h321));
    vq.push_back(px( 26, 105, 0, 0, 0, 'h322, 'h322));
    vq.push_back(px( 61, 185, 0, 0, 0, 'h323, 'h323));
    stream("cleared");

    // Unknown code 0x07 is stored but never drawn.
    push_one(5'h07); push_one(5'h07); push_one(5'h07);
    check("code07 next_block", 32'(next_block), 32'h07);
    vblank_rise(1'b0, 5'h0);
    vq.push_back(px( 26,  25, 0, 0, 0, 'h401, 'h401));
    vq.push_back(px( 61,  25, 0, 0, 0, 'h402, 'h402));
    vq.push_back(px( 43,  42, 0, 0, 0, 'h403, 'h403));
    vq.push_back(px(166,  25, 0, 0, 1, 'h404, 'h000));
    stream("code07");

    // Reset mid-line while a hit pixel is streaming.
    push_one(5'h10); push_one(5'h10); push_one(5'h10);
    vblank_rise(1'b0, 5'h0);
    drive_px(px(26, 25, 1, 1, 0, 'h5a5, 0));
    tick(); tick();
    check("pre-rst rgb", 32'(rgb_out), 32'hfab);
    rst = 1'b1;
    tick();
    check_all_zero("midrst");
    rst = 1'b0;
    tick();
    check("post-rst edge1 rgb", 32'(rgb_out), 32'(0));
    check("post-rst edge1 hcount", 32'(hcount_out), 32'(0));
    tick();
    check("post-rst edge2 rgb", 32'(rgb_out), 32'h5a5);
    check("post-rst edge2 hcount", 32'(hcount_out), 32'd26);
    check("post-rst edge2 hsync", 32'(hsync_out), 32'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
